// File: rtl/riscv_defs.sv
// riscv_defs: shared types and defaults for the pipeline memory port.
// Used by the arbiter and its starvation tracker.
package riscv_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_IF = 2'd1,
        ST_RD_DM = 2'd2
    } arb_state_t;

    localparam int MEM_LATENCY_DEF = 2;
    localparam int STARVE_MAX_DEF  = 4;
    localparam int LAT_W           = 3;
    localparam int STARVE_W        = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: fetch/data priority decision for the shared port,
// with a saturating count of data grants taken while fetch waits.
module arb_starve_cnt
    import riscv_defs::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
)(
    input  logic clk,
    input  logic reset_n,
    input  logic slot_open,
    input  logic if_req,
    input  logic if_flush,
    input  logic dm_req,
    output logic if_gnt,
    output logic dm_gnt
);

    localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;
    logic                if_ok;
    logic                starved;

    // data wins by default; a starved fetch takes the slot instead
    always_comb begin
        if_ok   = if_req & ~if_flush;
        starved = (starve_cnt == CNT_MAX);
        if_gnt  = slot_open & if_ok & (~dm_req | starved);
        dm_gnt  = slot_open & dm_req & ~if_gnt;
    end

    // count data grants that bypass a waiting fetch, saturating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (dm_gnt && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and
// load/store, tracks the outstanding read and routes its response.
module mem_port_arbiter
    import riscv_defs::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int STARVE_MAX  = STARVE_MAX_DEF
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        if_flush,
    input  logic        dm_req,
    input  logic        dm_wen,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

    arb_state_t       state, state_nx;
    logic [LAT_W-1:0] lat_cnt, lat_nx;
    logic             kill, kill_nx;
    logic             final_rd;
    logic             slot_open;

    assign final_rd  = (state != ST_IDLE) && (lat_cnt == '0);
    assign slot_open = reset_n & ((state == ST_IDLE) | final_rd);

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .slot_open (slot_open),
        .if_req    (if_req),
        .if_flush  (if_flush),
        .dm_req    (dm_req),
        .if_gnt    (if_gnt),
        .dm_gnt    (dm_gnt)
    );

    // state, latency countdown and fetch kill flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            kill    <= 1'b0;
        end else begin
            state   <= state_nx;
            lat_cnt <= lat_nx;
            kill    <= kill_nx;
        end
    end

    // count down a busy read; when the slot opens, take the next grant
    always_comb begin
        state_nx = state;
        lat_nx   = lat_cnt;
        kill_nx  = kill;
        if (state != ST_IDLE && !final_rd) begin
            lat_nx = lat_cnt - 1'b1;
            if (state == ST_RD_IF && if_flush) kill_nx = 1'b1;
        end else begin
            state_nx = ST_IDLE;
            lat_nx   = '0;
            kill_nx  = 1'b0;
            unique case (1'b1)
                if_gnt: begin
                    state_nx = ST_RD_IF;
                    lat_nx   = LAT_LOAD;
                end
                dm_gnt && !dm_wen: begin
                    state_nx = ST_RD_DM;
                    lat_nx   = LAT_LOAD;
                end
                default: ;
            endcase
        end
    end

    // drive the granted request to memory and route the response
    always_comb begin
        mem_en    = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        unique case (1'b1)
            if_gnt: begin
                mem_en   = 1'b1;
                mem_addr = if_addr;
            end
            dm_gnt: begin
                mem_en    = 1'b1;
                mem_wen   = dm_wen;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
                mem_be    = dm_be;
            end
            default: ;
        endcase
        if_rvalid = final_rd & (state == ST_RD_IF) & ~kill & ~if_flush;
        dm_rvalid = final_rd & (state == ST_RD_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
    end

endmodule
